// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
//
// Cleans one mechanical push-button input for synchronous logic. The raw level
// is brought into the clk domain through a flop chain. It is then filtered by a
// stability counter: a new level is accepted only after the synchronised input
// has differed from the current debounced level on STABLE_CYCLES consecutive
// edges.
//
// Parameters
//   SYNC_STAGES    synchroniser depth on noisy_in (2 or more)
//   STABLE_CYCLES  consecutive differing samples needed to accept a change
//                  (1 or more)
//   CNT_W          stability counter width, derived from STABLE_CYCLES;
//                  leave at its default
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   noisy_in     raw, asynchronous, bouncing button level (1 = pressed)
//   clean_pulse  one-cycle strobe on each accepted 0->1 transition (registered)
//   clean_level  debounced button level (registered)
// -----------------------------------------------------------------------------
module debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy_in,
  output logic clean_pulse,
  output logic clean_level
);

  // Terminal count: on the edge where the counter already holds this value
  // and the input still differs, the change is accepted. The counter
  // therefore never exceeds STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser chain
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   sync_in;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_head
        assign sync_next[gi] = noisy_in;
      end else begin : g_tail
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  // Only the last stage is considered safe to use in logic.
  assign sync_in = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             level_reg;
  logic             level_next;
  logic             pulse_reg;
  logic             pulse_next;

  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    pulse_next = 1'b0;
    if (sync_in == level_reg) begin
      // Any sample agreeing with the current level restarts qualification,
      // which is what rejects bounces shorter than STABLE_CYCLES.
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      level_next = sync_in;
      cnt_next   = '0;
      // Strobe only on presses; releases change the level silently.
      pulse_next = sync_in;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      pulse_reg <= pulse_next;
    end
  end

  assign clean_level = level_reg;
  assign clean_pulse = pulse_reg;

endmodule

// File: tb/tb_debounce.sv
// -----------------------------------------------------------------------------
// tb_debounce
//
// Directed phases (reset, bouncing press/release, glitch, long hold, reset
// during qualification) followed by randomized bouncing. Every clock edge is
// also compared with a reference model that works from the sample history:
// a level change is accepted when the last STABLE_CYCLES synchronised samples
// all differ from the current level and all were taken after the previous
// change.
// -----------------------------------------------------------------------------
module tb_debounce;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 8;
  // Edge index (0 = first edge sampling the new value) at which outputs move.
  localparam int ACCEPT_EDGE   = SYNC_STAGES + STABLE_CYCLES - 1;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic noisy_in = 1'b0;
  logic clean_pulse;
  logic clean_level;

  int tests     = 0;
  int fails     = 0;
  int pulse_cnt = 0;

  always #25 clk = ~clk;

  debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .noisy_in   (noisy_in),
    .clean_pulse(clean_pulse),
    .clean_level(clean_level)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit raw_q[$];        // noisy_in sampled on every functional edge since reset
  int last_change;     // edge index of the most recent accepted change
  bit m_level;
  bit m_pulse;
  int m_pulses;

  // Synchronised value the filter sees on edge j: raw sample from SYNC_STAGES
  // edges earlier, zero before reset release.
  function automatic bit sync_at(int j);
    if (j - SYNC_STAGES < 0) return 1'b0;
    return raw_q[j - SYNC_STAGES];
  endfunction

  task automatic model_reset();
    raw_q.delete();
    last_change = -1;
    m_level     = 1'b0;
    m_pulse     = 1'b0;
  endtask

  task automatic model_edge(input bit sample);
    int  n;
    bit  all_differ;
    raw_q.push_back(sample);
    n       = raw_q.size() - 1;
    m_pulse = 1'b0;
    if (n - last_change >= STABLE_CYCLES) begin
      all_differ = 1'b1;
      for (int j = n - STABLE_CYCLES + 1; j <= n; j++)
        if (sync_at(j) == m_level) all_differ = 1'b0;
      if (all_differ) begin
        m_level     = ~m_level;
        last_change = n;
        m_pulse     = m_level;
        if (m_pulse) m_pulses++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One functional clock edge, sampled 1 ns after it, checked against the model.
  task automatic step(input string tag);
    bit s;
    s = noisy_in;
    @(posedge clk);
    model_edge(s);
    #1;
    check({tag, "_model_level"}, clean_level, m_level);
    check({tag, "_model_pulse"}, clean_pulse, m_pulse);
    if (clean_pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic release_reset(input logic level_in);
    @(posedge clk);
    #1;
    noisy_in = level_in;
    rst      = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int run_len;
    logic v;
    int pulses_before;
    int model_before;

    model_reset();
    m_pulses = 0;

    // Reset with a toggling input: outputs must stay low throughout.
    #5 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #13 noisy_in = ~noisy_in;
      check("reset_level", clean_level, 1'b0);
      check("reset_pulse", clean_pulse, 1'b0);
    end
    release_reset(1'b0);
    for (int k = 0; k < 5; k++) step("idle");

    // Bouncing press: 1,0,1,0 then held high.
    pulse_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      noisy_in = (i % 2 == 0);
      step("press_bounce");
      check("press_bounce_pulse", clean_pulse, 1'b0);
    end
    for (int k = 0; k < 20; k++) begin
      noisy_in = 1'b1;
      step("press_hold");
      check("press_pulse_time", clean_pulse, (k == ACCEPT_EDGE));
      check("press_level_time", clean_level, (k >= ACCEPT_EDGE));
    end
    check("press_pulse_count", pulse_cnt, 1);

    // Bouncing release: 0,1,0,1 then held low.
    pulse_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      noisy_in = (i % 2 == 1);
      step("rel_bounce");
      check("rel_bounce_level", clean_level, 1'b1);
    end
    for (int k = 0; k < 20; k++) begin
      noisy_in = 1'b0;
      step("rel_hold");
      check("rel_level_time", clean_level, (k < ACCEPT_EDGE));
    end
    check("rel_pulse_count", pulse_cnt, 0);

    // Glitch of STABLE_CYCLES-1 cycles is rejected.
    pulse_cnt = 0;
    for (int k = 0; k < STABLE_CYCLES - 1 + 20; k++) begin
      noisy_in = (k < STABLE_CYCLES - 1);
      step("glitch");
      check("glitch_level", clean_level, 1'b0);
    end
    check("glitch_pulse_count", pulse_cnt, 0);

    // Long hold: exactly one pulse, no auto-repeat.
    pulse_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      noisy_in = 1'b1;
      step("long_hold");
    end
    check("long_pulse_count", pulse_cnt, 1);
    check("long_level", clean_level, 1'b1);
    for (int k = 0; k < 20; k++) begin
      noisy_in = 1'b0;
      step("long_release");
    end
    check("long_release_level", clean_level, 1'b0);

    // Reset during qualification, press held through release.
    noisy_in = 1'b1;
    for (int k = 0; k < 5; k++) step("rq_pre");
    #10 rst = 1'b0;
    #1;
    check("rq_async_level", clean_level, 1'b0);
    check("rq_async_pulse", clean_pulse, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("rq_hold_level", clean_level, 1'b0);
      check("rq_hold_pulse", clean_pulse, 1'b0);
    end
    release_reset(1'b1);
    pulse_cnt = 0;
    for (int k = 0; k <= ACCEPT_EDGE; k++) begin
      step("rq_post");
      check("rq_pulse_time", clean_pulse, (k == ACCEPT_EDGE));
      check("rq_level_time", clean_level, (k >= ACCEPT_EDGE));
    end
    check("rq_pulse_count", pulse_cnt, 1);

    // Asynchronous reset mid-cycle while the pulse is high.
    #10 rst = 1'b0;
    #1;
    check("async_pulse_clear", clean_pulse, 1'b0);
    check("async_level_clear", clean_level, 1'b0);
    release_reset(1'b0);
    for (int k = 0; k < 12; k++) step("post_async");

    // Randomized bouncing: runs of 1..12 cycles with alternating levels.
    pulses_before = pulse_cnt;
    model_before  = m_pulses;
    v = 1'b1;
    for (int r = 0; r < 60; r++) begin
      run_len = $urandom_range(1, 12);
      for (int k = 0; k < run_len; k++) begin
        noisy_in = v;
        step("random");
      end
      v = ~v;
    end
    check("random_pulse_total", pulse_cnt - pulses_before, m_pulses - model_before);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
